// File: rtl/cla_pipe_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: slice sizing,
// configuration sanity check and the expanded lookahead carry function.
package cla_pipe_pkg;

  localparam int unsigned MAX_SW = 32;

  function automatic int unsigned slice_width(input int unsigned bits, input int unsigned stages);
    return (stages == 0) ? bits : bits / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned bits, input int unsigned stages);
    return (stages >= 1) && (bits >= 1) && ((bits % stages) == 0) && ((bits / stages) <= MAX_SW);
  endfunction

  // Each carry is a flat OR of generate terms, so no carry depends on another.
  function automatic logic [MAX_SW:0] lookahead_carries(input logic [MAX_SW-1:0] p,
                                                        input logic [MAX_SW-1:0] g,
                                                        input logic              c);
    logic [MAX_SW:0] cv;
    logic            term;
    cv    = '0;
    cv[0] = c;
    for (int i = 0; i < int'(MAX_SW); i++) begin
      cv[i+1] = g[i];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        cv[i+1] = cv[i+1] | term;
      end
      term = c;
      for (int m = 0; m <= i; m++) term = term & p[m];
      cv[i+1] = cv[i+1] | term;
    end
    return cv;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The ovf signal exists only when CLA_PIPE_OVF_EN is defined.
interface cla_pipe_adder_if #(parameter int unsigned BITS = 16);

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic [BITS-1:0] b;
  logic            cin;
  logic            sub;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] sum;
  logic            cout;
`ifdef CLA_PIPE_OVF_EN
  logic            ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef CLA_PIPE_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/cla_slice.sv
// Combinational SW-bit carry-lookahead slice; also exposes the carry into
// its MSB so the top can derive signed overflow.
module cla_slice
  import cla_pipe_pkg::*;
#(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          c,
  output logic [SW-1:0] s,
  output logic          cout,
  output logic          msb_cin
);

  logic [SW-1:0]   p;
  logic [SW-1:0]   g;
  logic [MAX_SW:0] cv;

  assign p       = a ^ b;
  assign g       = a & b;
  assign cv      = lookahead_carries(MAX_SW'(p), MAX_SW'(g), c);
  assign s       = p ^ cv[SW-1:0];
  assign cout    = cv[SW];
  assign msb_cin = cv[SW-1];

  // Padding carries beyond the slice width are structurally zero-driven.
  if (SW < MAX_SW) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^cv[MAX_SW:SW+1];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit slice per stage,
// skew registers carry pending operands and finished result slices forward.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVF_EN.
module cla_pipe_adder
  import cla_pipe_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned STAGES = 4
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_adder_if.slave bus
);

  localparam int unsigned SW     = slice_width(BITS, STAGES);
  localparam bit          CFG_OK = cfg_ok(BITS, STAGES);

  if (!CFG_OK) begin : g_cfg_err
    $fatal(1, "cla_pipe_adder: BITS must be a multiple of STAGES (STAGES >= 1)");
  end

  logic              en_c;
  logic [BITS-1:0]   b_eff_c;
  logic              c0_c;
  logic [STAGES-1:0] valid_q;

  // Global stall: the whole pipe advances only when the output slot frees up.
  assign en_c         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en_c;
  assign b_eff_c      = bus.sub ? ~bus.b : bus.b;
  assign c0_c         = bus.sub | bus.cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (en_c) begin
      valid_q[0] <= bus.in_valid;
      for (int k = 1; k < int'(STAGES); k++) valid_q[k] <= valid_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned UP = BITS - (k + 1) * SW;

    logic [SW-1:0]         op_a;
    logic [SW-1:0]         op_b;
    logic                  cin_s;
    logic [SW-1:0]         s;
    logic                  co;
    logic                  mc;
    logic                  unused_mc;
    logic [(k+1)*SW-1:0]   sum_d;
    logic [(k+1)*SW-1:0]   sum_q;
    logic                  carry_q;

    if (k == 0) begin : g_src
      assign op_a  = bus.a[SW-1:0];
      assign op_b  = b_eff_c[SW-1:0];
      assign cin_s = c0_c;
      assign sum_d = s;
    end else begin : g_src
      assign op_a  = g_stg[k-1].g_ops.a_q[SW-1:0];
      assign op_b  = g_stg[k-1].g_ops.b_q[SW-1:0];
      assign cin_s = g_stg[k-1].carry_q;
      assign sum_d = {s, g_stg[k-1].sum_q};
    end

    cla_slice #(.SW(SW)) u_slice (
      .a       (op_a),
      .b       (op_b),
      .c       (cin_s),
      .s       (s),
      .cout    (co),
      .msb_cin (mc)
    );

    assign unused_mc = mc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (en_c) begin
        sum_q   <= sum_d;
        carry_q <= co;
      end
    end

    // Operand bits not yet consumed, shrinking by one slice per stage.
    if (k < STAGES - 1) begin : g_ops
      logic [UP-1:0] a_nx;
      logic [UP-1:0] b_nx;
      logic [UP-1:0] a_q;
      logic [UP-1:0] b_q;

      if (k == 0) begin : g_nx
        assign a_nx = bus.a[BITS-1:SW];
        assign b_nx = b_eff_c[BITS-1:SW];
      end else begin : g_nx
        assign a_nx = g_stg[k-1].g_ops.a_q[UP+SW-1:SW];
        assign b_nx = g_stg[k-1].g_ops.b_q[UP+SW-1:SW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en_c) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = g_stg[STAGES-1].sum_q;
  assign bus.cout      = g_stg[STAGES-1].carry_q;

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into MSB disagrees with carry out of MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en_c) begin
      ovf_q <= g_stg[STAGES-1].mc ^ g_stg[STAGES-1].co;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
